// File: rtl/button_toggle_conditioner_pkg.sv
// Shared definitions for the push-button conditioner.
// Contents:
//   - btn_fsm_e : debounce FSM state encoding (2 bits).
//   - Default timing constants for a 50 MHz clock.
//   - cnt_fits(): elaboration-time check that a counter width can hold a terminal count.
package button_toggle_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED     = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } btn_fsm_e;

  // 10 ms debounce and 1 s hold at 50 MHz.
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 500000;
  localparam int unsigned DEF_HOLD_CYCLES     = 50000000;
  localparam int unsigned DEF_CNT_W           = 26;

  // True when a CNT_W-bit counter can represent the value last_val.
  function automatic bit cnt_fits(input int unsigned w, input int unsigned last_val);
    longint unsigned lim;
    lim = longint'(1) << w;
    return (longint'(last_val) < lim);
  endfunction

endpackage

// File: rtl/button_toggle_conditioner_if.sv
// Button-side bundle for the conditioner.
// Signals:
//   toggleBtn      raw active-low button (0 = pressed), asynchronous
//   btn_state      debounced level, 1 = pressed
//   press_pulse    one-cycle strobe on accepted press
//   release_pulse  one-cycle strobe on accepted release
//   hold_pulse     one-cycle strobe, once per press, after the hold time
//   run_en         run/stop flag, toggles on every accepted press
// Modports:
//   master : board/consumer side, drives the button and reads the results
//   slave  : conditioner side
interface button_toggle_conditioner_if;
  logic toggleBtn;
  logic btn_state;
  logic press_pulse;
  logic release_pulse;
  logic hold_pulse;
  logic run_en;

  modport master (
    output toggleBtn,
    input  btn_state, press_pulse, release_pulse, hold_pulse, run_en
  );

  modport slave (
    input  toggleBtn,
    output btn_state, press_pulse, release_pulse, hold_pulse, run_en
  );
endinterface

// File: rtl/button_toggle_conditioner_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
// The reset value is a parameter so idle-high inputs (active-low buttons)
// come out of reset in their inactive state.
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   d_i     asynchronous input
//   q_o     synchronised output (second stage)
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/button_toggle_conditioner.sv
// Conditioner for the raw active-low toggle button.
// Synchronises the button, debounces it with a counter-based FSM, emits
// one-cycle press/release/hold strobes and keeps the run/stop flag.
// Ports:
//   CLOCK_50  system clock, rising edge
//   reset_n   asynchronous active-low reset
//   btn       slave side of button_toggle_conditioner_if
//             (toggleBtn in; btn_state, press_pulse, release_pulse,
//              hold_pulse, run_en out -- all registered)
module button_toggle_conditioner
  import button_toggle_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned CNT_W           = DEF_CNT_W
) (
  input  logic                        CLOCK_50,
  input  logic                        reset_n,
  button_toggle_conditioner_if.slave  btn
);

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  // Elaboration guard: a too-narrow counter would silently wrap.
  if (!cnt_fits(CNT_W, DEBOUNCE_CYCLES - 1) || !cnt_fits(CNT_W, HOLD_CYCLES - 1)) begin : g_bad_cnt_w
    $error("CNT_W too small for DEBOUNCE_CYCLES/HOLD_CYCLES");
  end

  logic btn_s;   // synced raw level, 0 = pressed

  sync_2ff #(.RST_VAL(1'b1)) u_sync (
    .clk_i  (CLOCK_50),
    .rst_ni (reset_n),
    .d_i    (btn.toggleBtn),
    .q_o    (btn_s)
  );

  btn_fsm_e         state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             level_q;
  logic             press_q;
  logic             release_q;
  logic             hold_q;
  logic             hold_done_q;  // hold already fired for this press
  logic             run_q;

  // One counter serves three purposes: press qualification, release
  // qualification, and the hold timer while PRESSED.  Because a short
  // release glitch clears and reuses it, hold_done_q is what guarantees a
  // single hold strobe per accepted press.
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_RELEASED;
      cnt_q       <= '0;
      level_q     <= 1'b0;
      press_q     <= 1'b0;
      release_q   <= 1'b0;
      hold_q      <= 1'b0;
      hold_done_q <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      hold_q    <= 1'b0;
      case (state_q)
        ST_RELEASED: begin
          if (!btn_s) begin
            state_q <= ST_WAIT_PRESS;
            cnt_q   <= '0;
          end
        end
        ST_WAIT_PRESS: begin
          if (btn_s) begin
            state_q <= ST_RELEASED;   // bounce: restart qualification
            cnt_q   <= '0;
          end else if (cnt_q == DEB_LAST) begin
            state_q     <= ST_PRESSED;
            cnt_q       <= '0;
            press_q     <= 1'b1;
            level_q     <= 1'b1;
            run_q       <= ~run_q;
            hold_done_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        ST_PRESSED: begin
          if (btn_s) begin
            state_q <= ST_WAIT_RELEASE;
            cnt_q   <= '0;
          end else begin
            if (cnt_q < HOLD_LAST) cnt_q <= cnt_q + CNT_ONE;
            // >= rather than == : after a glitch the reused count may
            // already exceed the hold terminal value.
            if (cnt_q >= HOLD_LAST && !hold_done_q) begin
              hold_q      <= 1'b1;
              hold_done_q <= 1'b1;
            end
          end
        end
        ST_WAIT_RELEASE: begin
          if (!btn_s) begin
            state_q <= ST_PRESSED;    // glitch: counter deliberately kept
          end else if (cnt_q == DEB_LAST) begin
            state_q   <= ST_RELEASED;
            cnt_q     <= '0;
            release_q <= 1'b1;
            level_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_q <= ST_RELEASED;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign btn.btn_state     = level_q;
  assign btn.press_pulse   = press_q;
  assign btn.release_pulse = release_q;
  assign btn.hold_pulse    = hold_q;
  assign btn.run_en        = run_q;

endmodule

// File: tb/tb_button_toggle_conditioner.sv
// Self-checking bench: directed scenarios plus random button activity,
// compared every cycle against a run-length reference model.
module tb_button_toggle_conditioner;

  localparam int D = 16;
  localparam int H = 64;

  logic clk;
  logic rst_n;

  button_toggle_conditioner_if bif ();

  button_toggle_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H),
    .CNT_W           (26)
  ) dut (
    .CLOCK_50 (clk),
    .reset_n  (rst_n),
    .btn      (bif.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: synced sample delayed two edges; a level change is
  // accepted after D+1 consecutive opposing samples; hold fires once when
  // the press has been held H-1 counted cycles.
  bit m_s1, m_s2, m_acc, m_runen, m_fired;
  bit m_press, m_rel, m_hold;
  int m_run, m_ht;

  task automatic model_reset();
    m_s1 = 1; m_s2 = 1; m_acc = 0; m_runen = 0; m_fired = 0;
    m_press = 0; m_rel = 0; m_hold = 0; m_run = 0; m_ht = 0;
  endtask

  task automatic model_edge(input bit b);
    bit s;
    s = m_s2; m_s2 = m_s1; m_s1 = b;
    m_press = 0; m_rel = 0; m_hold = 0;
    if (!m_acc) begin
      if (s == 0) begin
        m_run++;
        if (m_run == D + 1) begin
          m_acc = 1; m_press = 1; m_runen = ~m_runen;
          m_run = 0; m_ht = 0; m_fired = 0;
        end
      end else m_run = 0;
    end else begin
      if (s == 1) begin
        m_run++;
        if (m_run == D + 1) begin
          m_acc = 0; m_rel = 1; m_run = 0;
        end
      end else if (m_run > 0) begin
        // return from a short release glitch: the release run length
        // becomes the hold timer value
        m_ht = m_run - 1; m_run = 0;
      end else begin
        if (m_ht >= H - 1 && !m_fired) begin m_hold = 1; m_fired = 1; end
        if (m_ht < H - 1) m_ht++;
      end
    end
  endtask

  int cyc = 0;
  int press_at, rel_at, hold_at;
  int n_press, n_rel, n_hold;

  task automatic clr_counts();
    n_press = 0; n_rel = 0; n_hold = 0;
    press_at = -1; rel_at = -1; hold_at = -1;
  endtask

  function automatic logic [4:0] outs();
    return {bif.btn_state, bif.press_pulse, bif.release_pulse, bif.hold_pulse, bif.run_en};
  endfunction

  task automatic tick(input bit b);
    bif.toggleBtn = b;
    @(posedge clk);
    cyc++;
    model_edge(b);
    #1;
    chk("outs", 32'(outs()), 32'({m_acc, m_press, m_rel, m_hold, m_runen}));
    if (bif.press_pulse)   begin n_press++; press_at = cyc; end
    if (bif.release_pulse) begin n_rel++;   rel_at = cyc;   end
    if (bif.hold_pulse)    begin n_hold++;  hold_at = cyc;  end
  endtask

  task automatic ticks(input bit b, input int n);
    for (int i = 0; i < n; i++) tick(b);
  endtask

  // Called just after a rising edge; checks async clear before the next edge.
  task automatic do_reset(input bit b);
    bif.toggleBtn = b;
    rst_n = 1'b0;
    #1;
    chk("rst_async", 32'(outs()), 32'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  int t0;

  initial begin
    bif.toggleBtn = 1'b1;
    rst_n = 1'b1;
    model_reset();
    clr_counts();
    #5;
    // 1. reset pulse with button released, then idle
    rst_n = 1'b0;
    #20;
    chk("rst_outs", 32'(outs()), 32'd0);
    rst_n = 1'b1;
    ticks(1, 200);
    chk("idle_strobes", 32'(n_press + n_rel + n_hold), 32'd0);

    // 2. clean press and release
    clr_counts();
    t0 = cyc + 1;
    ticks(0, 40);
    chk("press_lat", 32'(press_at - t0), 32'd18);
    chk("press_cnt", 32'(n_press), 32'd1);
    chk("run_en_on", 32'(bif.run_en), 32'd1);
    chk("level_hi", 32'(bif.btn_state), 32'd1);
    t0 = cyc + 1;
    ticks(1, 30);
    chk("rel_lat", 32'(rel_at - t0), 32'd18);
    chk("level_lo", 32'(bif.btn_state), 32'd0);

    // 3. bounce before qualification
    clr_counts();
    ticks(0, 10);
    ticks(1, 3);
    t0 = cyc + 1;
    ticks(0, 30);
    chk("bounce_cnt", 32'(n_press), 32'd1);
    chk("bounce_lat", 32'(press_at - t0), 32'd18);
    ticks(1, 30);

    // 4. long hold with a short glitch after the hold strobe
    clr_counts();
    t0 = cyc + 1;
    ticks(0, 100);
    ticks(1, 5);
    ticks(0, 15);
    chk("hold_press_lat", 32'(press_at - t0), 32'd18);
    chk("hold_lat", 32'(hold_at - press_at), 32'd64);
    chk("hold_once", 32'(n_hold), 32'd1);
    chk("glitch_no_rel", 32'(n_rel), 32'd0);
    ticks(1, 30);
    chk("hold_final_rel", 32'(n_rel), 32'd1);

    // 5. reset during press qualification, button kept low
    clr_counts();
    ticks(0, 10);
    do_reset(0);
    t0 = cyc + 1;
    ticks(0, 30);
    chk("rst_wp_press_cnt", 32'(n_press), 32'd1);
    chk("rst_wp_lat", 32'(press_at - t0), 32'd18);
    ticks(1, 30);

    // 6. two full cycles from reset
    do_reset(1);
    clr_counts();
    ticks(0, 25);
    chk("two_run1", 32'(bif.run_en), 32'd1);
    ticks(1, 25);
    ticks(0, 25);
    chk("two_run0", 32'(bif.run_en), 32'd0);
    ticks(1, 25);
    chk("two_press", 32'(n_press), 32'd2);
    chk("two_rel", 32'(n_rel), 32'd2);

    // random activity, including glitches before and after hold
    for (int seg = 0; seg < 60; seg++) begin
      int len;
      bit lvl;
      lvl = 1'($urandom_range(0, 1));
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(60, 90)) : int'($urandom_range(1, 24));
      ticks(lvl, len);
    end
    ticks(1, 30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
